// File: rtl/uart_rx_fifo.sv
// UART receive byte buffer: edge-detected capture, error filtering,
// first-word-fall-through FIFO with fill level and sticky overflow.
module uart_rx_fifo #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 16,
    parameter int ADDR_W     = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] in_data,
    input  logic                  in_vld,
    input  logic                  in_err,
    input  logic                  clr,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [ADDR_W:0]       level,
    output logic                  full,
    output logic                  overflow,
    output logic [7:0]            err_cnt
);

    localparam logic [ADDR_W:0]   LVL_FULL = (ADDR_W + 1)'(DEPTH);
    localparam logic [ADDR_W:0]   LVL_ONE  = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
    localparam logic [7:0]        ERR_MAX  = 8'hFF;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   level_q, level_d;
    logic              in_vld_q;
    logic              overflow_q, overflow_d;
    logic [7:0]        err_cnt_q, err_cnt_d;

    logic wr_evt;
    logic pop;
    logic wr_acc;
    logic wr_drop;
    logic wr_bad;
    logic full_s;
    logic valid_s;

    // Status flags come from registered occupancy only.
    always_comb begin
        full_s  = (level_q == LVL_FULL);
        valid_s = (level_q != '0);
    end

    // Classify this cycle's write event and pop.
    always_comb begin
        wr_evt  = in_vld & ~in_vld_q;
        pop     = valid_s & m_ready;
        wr_bad  = wr_evt & in_err;
        wr_acc  = wr_evt & ~in_err & (~full_s | pop);
        wr_drop = wr_evt & ~in_err & full_s & ~pop;
    end

    // Next-state for pointers, level, overflow flag and error counter.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        level_d    = level_q;
        overflow_d = overflow_q;
        err_cnt_d  = err_cnt_q;

        if (wr_acc) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end

        if (wr_acc && !pop) begin
            level_d = level_q + LVL_ONE;
        end else if (pop && !wr_acc) begin
            level_d = level_q - LVL_ONE;
        end

        if (wr_drop) begin
            overflow_d = 1'b1;
        end
        if (wr_bad && err_cnt_q != ERR_MAX) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end

        // Clear takes priority over a coincident drop or error event.
        if (clr) begin
            overflow_d = 1'b0;
            err_cnt_d  = '0;
        end
    end

    // Control state; edge detector resets high so a held valid is ignored.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            in_vld_q   <= 1'b1;
            overflow_q <= 1'b0;
            err_cnt_q  <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            in_vld_q   <= in_vld;
            overflow_q <= overflow_d;
            err_cnt_q  <= err_cnt_d;
        end
    end

    // Storage array; contents need no reset since pointers define validity.
    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    // Head of FIFO falls through; forced to zero while empty.
    always_comb begin
        m_data   = valid_s ? mem_q[rd_ptr_q] : '0;
        m_valid  = valid_s;
        level    = level_q;
        full     = full_s;
        overflow = overflow_q;
        err_cnt  = err_cnt_q;
    end

endmodule
